rx_frame_deserializer: RTL and testbench

Parametrised UART receive-path deserializer. It sits between the bit sampler and the receive data consumer.
It accepts validated sampled bits with a per-bit strobe, then assembles a data word of configurable width and bit order.
It checks the optional parity bit and the stop bit, and presents the word on a valid/ready output handshake with error pulses.
It replaces the bare shift register with a self-counting, frame-aware block.

---
 rtl/rx_frame_deserializer_if.sv | 28 ++
 rtl/rx_frame_deserializer.sv | 129 ++++++++++++
 tb/tb_rx_frame_deserializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_deserializer_if.sv
// Handshake/bus bundle between the bit sampler, the frame deserializer and the
// receive data consumer. The master side drives sampler/consumer inputs.
interface rx_frame_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start_det;
  logic                  sampled_bit;
  logic                  bit_strobe;
  logic                  par_en;
  logic                  par_type;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  ovr_err;
  logic                  busy;

  modport master (
    output start_det, sampled_bit, bit_strobe, par_en, par_type, data_ready,
    input  P_DATA, data_valid, par_err, stp_err, ovr_err, busy
  );

  modport slave (
    input  start_det, sampled_bit, bit_strobe, par_en, par_type, data_ready,
    output P_DATA, data_valid, par_err, stp_err, ovr_err, busy
  );
endinterface

// File: rtl/rx_frame_deserializer.sv
// UART receive frame deserializer: counts data bits, checks parity/stop, and
// presents good words on a valid/ready handshake. RX_DESER_OVERRUN_EN drops overrun words.
module rx_frame_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  rx_frame_deserializer_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic [CW-1:0]         r_cnt;
  logic                  r_acc;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_perr;
  logic                  r_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
`ifdef RX_DESER_OVERRUN_EN
  logic                  r_ovr_err;
`endif

  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_serr;
  logic                  w_done;
  logic                  w_good;
  logic                  w_consume;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shift = {r_sr[DATA_WIDTH-2:0], bus.sampled_bit};
    end else begin : g_lsb
      assign w_shift = {bus.sampled_bit, r_sr[DATA_WIDTH-1:1]};
    end
  endgenerate

  assign w_serr    = ~bus.sampled_bit;
  assign w_done    = (r_state == STOP) && bus.bit_strobe;
  assign w_good    = w_done && !r_perr && !w_serr;
  assign w_consume = r_valid && bus.data_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_sr       <= '0;
      r_pdata    <= '0;
      r_cnt      <= '0;
      r_acc      <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
      r_perr     <= 1'b0;
      r_valid    <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
`ifdef RX_DESER_OVERRUN_EN
      r_ovr_err  <= 1'b0;
`endif
    end else begin
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
`ifdef RX_DESER_OVERRUN_EN
      r_ovr_err <= 1'b0;
`endif
      case (r_state)
        IDLE: if (bus.start_det) begin
          r_par_en   <= bus.par_en;
          r_par_type <= bus.par_type;
          r_sr       <= '0;
          r_cnt      <= '0;
          r_acc      <= 1'b0;
          r_perr     <= 1'b0;
          r_state    <= DATA;
        end
        DATA: if (bus.bit_strobe) begin
          r_sr  <= w_shift;
          r_acc <= r_acc ^ bus.sampled_bit;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(DATA_WIDTH-1))
            r_state <= r_par_en ? PARITY : STOP;
        end
        PARITY: if (bus.bit_strobe) begin
          // acc holds XOR of the data bits; odd parity inverts the expected bit
          r_perr  <= (bus.sampled_bit != (r_acc ^ r_par_type));
          r_state <= STOP;
        end
        STOP: if (bus.bit_strobe) begin
          r_par_err <= r_perr;
          r_stp_err <= w_serr;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A consume in the completion cycle frees the slot, so that is not an overrun
      if (w_good) begin
        if (r_valid && !bus.data_ready) begin
`ifdef RX_DESER_OVERRUN_EN
          r_ovr_err <= 1'b1;
`else
          r_pdata   <= r_sr;
`endif
        end else begin
          r_pdata <= r_sr;
          r_valid <= 1'b1;
        end
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.P_DATA     = r_pdata;
  assign bus.data_valid = r_valid;
  assign bus.par_err    = r_par_err;
  assign bus.stp_err    = r_stp_err;
  assign bus.busy       = (r_state != IDLE);
`ifdef RX_DESER_OVERRUN_EN
  assign bus.ovr_err    = r_ovr_err;
`else
  assign bus.ovr_err    = 1'b0;
`endif
endmodule

// File: tb/tb_rx_frame_deserializer.sv
// Directed bench for rx_frame_deserializer: LSB-first and MSB-first instances
// driven in lockstep, expected frame outcomes queued and popped at completion.
module tb_rx_frame_deserializer;
  logic CLK;
  logic RST;
  logic start_det, sampled_bit, bit_strobe, par_en, par_type, data_ready;

  int n_checks = 0;
  int n_errors = 0;

  rx_frame_deserializer_if #(.DATA_WIDTH(8)) if0 ();
  rx_frame_deserializer_if #(.DATA_WIDTH(8)) if1 ();

  assign if0.start_det = start_det;   assign if1.start_det = start_det;
  assign if0.sampled_bit = sampled_bit; assign if1.sampled_bit = sampled_bit;
  assign if0.bit_strobe = bit_strobe; assign if1.bit_strobe = bit_strobe;
  assign if0.par_en = par_en;         assign if1.par_en = par_en;
  assign if0.par_type = par_type;     assign if1.par_type = par_type;
  assign if0.data_ready = data_ready; assign if1.data_ready = data_ready;

  rx_frame_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut0 (.CLK(CLK), .RST(RST), .bus(if0.slave));
  rx_frame_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] p0;
    logic [7:0] p1;
    logic       vld;
    logic       perr;
    logic       serr;
    logic       ovr;
  } exp_t;

  exp_t q[$];
  logic [7:0] mp0, mp1;
  logic       mvalid;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle_pulses(input string tag);
    chk({tag, "_perr0"}, {31'd0, if0.par_err}, 32'd0);
    chk({tag, "_serr0"}, {31'd0, if0.stp_err}, 32'd0);
    chk({tag, "_ovr0"},  {30'd0, if0.ovr_err, if1.ovr_err}, 32'd0);
    chk({tag, "_busy0"}, {30'd0, if0.busy, if1.busy}, 32'd0);
  endtask

  // d is listed in reception order: d[0] is the first data bit on the line
  task automatic send_frame(input string tag, input logic [7:0] d, input bit pe, input bit pt,
                            input bit pb, input bit stop, input bit rdy, input bit mid);
    exp_t e, g;
    logic good;
    par_en = pe; par_type = pt; start_det = 1'b1;
    tick();
    start_det = 1'b0; par_en = 1'b0; par_type = 1'b0;
    chk({tag, "_busy"}, {30'd0, if0.busy, if1.busy}, 32'd3);
    for (int i = 0; i < 8; i++) begin
      sampled_bit = d[i]; bit_strobe = 1'b1;
      if (mid && i == 3) begin
        start_det = 1'b1; par_en = 1'b1;
      end
      tick();
      start_det = 1'b0; par_en = 1'b0;
    end
    if (pe) begin
      sampled_bit = pb;
      tick();
    end
    e.perr = pe && (pb != ((^d) ^ pt));
    e.serr = !stop;
    e.ovr  = 1'b0;
    good   = !e.perr && !e.serr;
    if (good) begin
      if (mvalid && !rdy) begin
`ifdef RX_DESER_OVERRUN_EN
        e.ovr = 1'b1;
`else
        mp0 = d; mp1 = rev8(d);
`endif
      end else begin
        mp0 = d; mp1 = rev8(d); mvalid = 1'b1;
      end
    end else if (mvalid && rdy) begin
      mvalid = 1'b0;
    end
    e.p0 = mp0; e.p1 = mp1; e.vld = mvalid;
    q.push_back(e);
    sampled_bit = stop; data_ready = rdy;
    tick();
    bit_strobe = 1'b0; data_ready = 1'b0;
    g = q.pop_front();
    chk({tag, "_pdata0"}, {24'd0, if0.P_DATA}, {24'd0, g.p0});
    chk({tag, "_pdata1"}, {24'd0, if1.P_DATA}, {24'd0, g.p1});
    chk({tag, "_valid"},  {30'd0, if0.data_valid, if1.data_valid}, {30'd0, g.vld, g.vld});
    chk({tag, "_perr"},   {30'd0, if0.par_err, if1.par_err}, {30'd0, g.perr, g.perr});
    chk({tag, "_serr"},   {30'd0, if0.stp_err, if1.stp_err}, {30'd0, g.serr, g.serr});
    chk({tag, "_ovr"},    {30'd0, if0.ovr_err, if1.ovr_err}, {30'd0, g.ovr, g.ovr});
    tick();
    chk_idle_pulses(tag);
  endtask

  task automatic consume(input string tag);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    mvalid = 1'b0;
    chk({tag, "_consumed"}, {30'd0, if0.data_valid, if1.data_valid}, 32'd0);
  endtask

  initial begin
    RST = 1'b0; start_det = 1'b0; sampled_bit = 1'b0; bit_strobe = 1'b0;
    par_en = 1'b0; par_type = 1'b0; data_ready = 1'b0;
    mp0 = 8'h00; mp1 = 8'h00; mvalid = 1'b0;
    #12;
    chk("rst_pdata", {if0.P_DATA, if1.P_DATA}, 32'd0);
    chk("rst_flags", {26'd0, if0.data_valid, if1.data_valid, if0.par_err, if0.stp_err,
                      if0.ovr_err, if0.busy}, 32'd0);
    tick();
    RST = 1'b1;
    tick();

    // bits 1,0,1,0,0,1,0,1: 0xA5 in either bit order
    send_frame("a5", 8'hA5, 0, 0, 0, 1, 0, 0);
    chk("a5_const", {if0.P_DATA, if1.P_DATA}, 32'hA5A5);
    consume("a5");

    // bits 1,1,0,0,0,0,0,0
    send_frame("b03", 8'h03, 0, 0, 0, 1, 0, 0);
    chk("b03_const", {if0.P_DATA, if1.P_DATA}, 32'h03C0);
    consume("b03");

    send_frame("p37ok", 8'h37, 1, 0, 1, 1, 0, 0);
    chk("p37_const", {24'd0, if0.P_DATA}, 32'h37);
    consume("p37ok");
    send_frame("p37bad", 8'h37, 1, 0, 0, 1, 0, 0);
    chk("p37bad_hold", {24'd0, if0.P_DATA}, 32'h37);

    send_frame("stopbad", 8'h5A, 0, 0, 0, 0, 0, 0);
    send_frame("bothbad", 8'h37, 1, 0, 0, 0, 0, 0);

    send_frame("ovr11", 8'h11, 0, 0, 0, 1, 0, 0);
    send_frame("ovr22", 8'h22, 0, 0, 0, 1, 0, 0);
`ifdef RX_DESER_OVERRUN_EN
    chk("ovr_keep", {24'd0, if0.P_DATA}, 32'h11);
`else
    chk("ovr_over", {24'd0, if0.P_DATA}, 32'h22);
`endif
    // consume in the completion cycle: new word loads, valid stays high
    send_frame("swap33", 8'h33, 0, 0, 0, 1, 1, 0);
    chk("swap33_const", {23'd0, if0.data_valid, if0.P_DATA}, 32'h133);
    consume("swap33");

    send_frame("odd37", 8'h37, 1, 1, 0, 1, 0, 0);
    send_frame("oddbad", 8'h36, 1, 1, 0, 1, 0, 0);
    consume("odd37");

    // reset mid-frame after 4 data strobes
    start_det = 1'b1;
    tick();
    start_det = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sampled_bit = 1'b1; bit_strobe = 1'b1;
      tick();
    end
    bit_strobe = 1'b0;
    chk("midrst_busy", {30'd0, if0.busy, if1.busy}, 32'd3);
    RST = 1'b0;
    #1;
    mp0 = 8'h00; mp1 = 8'h00; mvalid = 1'b0;
    chk("midrst_busy0", {30'd0, if0.busy, if1.busy}, 32'd0);
    chk("midrst_pdata", {if0.P_DATA, if1.P_DATA}, 32'd0);
    tick();
    RST = 1'b1;
    // strobes in IDLE must not shift anything in
    for (int i = 0; i < 3; i++) begin
      sampled_bit = 1'b1; bit_strobe = 1'b1;
      tick();
    end
    bit_strobe = 1'b0;
    chk("idle_strobe_busy", {30'd0, if0.busy, if1.busy}, 32'd0);
    send_frame("f81", 8'h81, 0, 0, 0, 1, 0, 1);
    chk("f81_const", {if0.P_DATA, if1.P_DATA}, 32'h8181);
    consume("f81");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
